// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, H/V counters and registered sync/blank/markers
// with a PIPE-deep alignment delay. Defining VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame_count output.
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int PIPE     = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          En,
  output logic          pixel_ce,
  output logic          pixel_clk,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]   frame_count,
`endif
  output logic          vblank
);
  // state | meaning
  // IDLE  | halted or freshly enabled; the next pixel tick loads (0,0)
  // RUN   | counters advance on every pixel tick
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > 2**CW) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL exceeds 2**CW");
  end
  if (V_TOTAL > 2**CW) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL exceeds 2**CW");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be 0..7");
  end

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   H_ACT    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   V_ACT    = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   HS_BEG   = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   VS_BEG   = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  // Stage bit layout; every bit is stored as "asserted", polarity is applied at the pins.
  localparam int B_HS = 5;
  localparam int B_VS = 4;
  localparam int B_BL = 3;
  localparam int B_LS = 2;
  localparam int B_FS = 1;
  localparam int B_VB = 0;

  state_t             state_q;
  logic [DW-1:0]      div_q, div_d;
  logic               pixel_ce_q, pixel_clk_q;
  logic [CW-1:0]      x_q, y_q, x_d, y_d;
  logic [5:0]         dec_d;
  logic [PIPE:0][5:0] stage_q;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (state_q == ST_IDLE) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end else begin
      x_d = x_q + 1'b1;
    end
  end

  // Decode the position the counters are about to take, so stage 0 lines up with DrawX/DrawY.
  always_comb begin
    dec_d       = '0;
    dec_d[B_HS] = ({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END);
    dec_d[B_VS] = ({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END);
    dec_d[B_BL] = ({1'b0, x_d} < H_ACT) && ({1'b0, y_d} < V_ACT);
    dec_d[B_LS] = (x_d == '0);
    dec_d[B_FS] = (x_d == '0) && (y_d == '0);
    dec_d[B_VB] = ({1'b0, y_d} >= V_ACT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      pixel_ce_q  <= 1'b0;
      pixel_clk_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      stage_q     <= '0;
    end else if (!En) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      pixel_ce_q  <= 1'b0;
      pixel_clk_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      stage_q     <= '0;
    end else begin
      div_q       <= div_d;
      pixel_ce_q  <= (div_d == DIV_LAST);
      pixel_clk_q <= (div_d < DIV_HALF);
      if (pixel_ce_q) begin
        state_q    <= ST_RUN;
        x_q        <= x_d;
        y_q        <= y_d;
        stage_q[0] <= dec_d;
        for (int i = 1; i <= PIPE; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  // Counts stage-0 frame starts, deliberately ahead of the PIPE delay.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fcnt_q <= '0;
    end else if (!En) begin
      fcnt_q <= '0;
    end else if (pixel_ce_q && dec_d[B_FS]) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign frame_count = fcnt_q;
`endif

  assign pixel_ce    = pixel_ce_q;
  assign pixel_clk   = pixel_clk_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = stage_q[PIPE][B_HS] ^ ~HS_POL;
  assign vs          = stage_q[PIPE][B_VS] ^ ~VS_POL;
  assign blank       = stage_q[PIPE][B_BL];
  assign line_start  = stage_q[PIPE][B_LS];
  assign frame_start = stage_q[PIPE][B_FS];
  assign vblank      = stage_q[PIPE][B_VB];
  assign sync        = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances (plain, and inverted-polarity/divide-4/PIPE-3)
// compared every Clk against an arithmetic model driven by the count of enabled Clk edges.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  localparam int DA = 2, PA = 0;
  localparam int DB = 4, PB = 3;

  typedef struct packed {
    logic ce, pclk, hs, vs, bl, ls, fs, vb;
    logic [15:0] x, y, fc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic En = 1'b0;

  logic ce_a, pclk_a, hs_a, vs_a, bl_a, sy_a, ls_a, fs_a, vb_a;
  logic [9:0] x_a, y_a;
  logic ce_b, pclk_b, hs_b, vs_b, bl_b, sy_b, ls_b, fs_b, vb_b;
  logic [5:0] x_b, y_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  always #5 Clk = ~Clk;

  vga_timing_gen #(
    .CW(10), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(DA), .PIPE(PA)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .En(En),
    .pixel_ce(ce_a), .pixel_clk(pclk_a), .hs(hs_a), .vs(vs_a), .blank(bl_a), .sync(sy_a),
    .DrawX(x_a), .DrawY(y_a), .line_start(ls_a), .frame_start(fs_a),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_count(fc_a),
`endif
    .vblank(vb_a)
  );

  vga_timing_gen #(
    .CW(6), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(DB), .PIPE(PB)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .En(En),
    .pixel_ce(ce_b), .pixel_clk(pclk_b), .hs(hs_b), .vs(vs_b), .blank(bl_b), .sync(sy_b),
    .DrawX(x_b), .DrawY(y_b), .line_start(ls_b), .frame_start(fs_b),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_count(fc_b),
`endif
    .vblank(vb_b)
  );

  // k = number of consecutive Clk edges that sampled En = 1 since the last reset/halt.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) k <= 0;
    else if (!En) k <= 0;
    else k <= k + 1;
  end

  // Pixel tick t happens every d enabled edges; tick n shows raster position n-1, and the
  // delayed outputs show position n-1-pipe (inactive before the pipe has filled).
  function automatic exp_t model(input int kk, input int d, input int pipe, input bit hp, input bit vp);
    exp_t e;
    int t, p, q, qx, qy;
    bit hsa, vsa;
    e = '0;
    t = kk / d;
    e.ce = ((kk % d) == d - 1);
    e.pclk = (kk > 0) && ((kk % d) < d / 2);
    if (t > 0) begin
      p = t - 1;
      e.x  = 16'(p % HT);
      e.y  = 16'((p / HT) % VT);
      e.fc = 16'(((p / FT) + 1) % 65536);
    end
    q = t - 1 - pipe;
    hsa = 1'b0;
    vsa = 1'b0;
    if (q >= 0) begin
      qx = q % HT;
      qy = (q / HT) % VT;
      hsa  = (qx >= HA + HF) && (qx < HA + HF + HSY);
      vsa  = (qy >= VA + VF) && (qy < VA + VF + VSY);
      e.bl = (qx < HA) && (qy < VA);
      e.ls = (qx == 0);
      e.fs = (qx == 0) && (qy == 0);
      e.vb = (qy >= VA);
    end
    e.hs = hp ? hsa : !hsa;
    e.vs = vp ? vsa : !vsa;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h k=%0d t=%0t", tag, obs, expv, k, $time);
    end
  endtask

  task automatic check_dut(input string nm, input exp_t e,
                           input logic ce, input logic pclk, input logic hs, input logic vs,
                           input logic bl, input logic sy, input logic ls, input logic fs,
                           input logic vb, input logic [31:0] x, input logic [31:0] y);
    chk({nm, ".pixel_ce"}, 32'(ce), 32'(e.ce));
    chk({nm, ".pixel_clk"}, 32'(pclk), 32'(e.pclk));
    chk({nm, ".hs"}, 32'(hs), 32'(e.hs));
    chk({nm, ".vs"}, 32'(vs), 32'(e.vs));
    chk({nm, ".blank"}, 32'(bl), 32'(e.bl));
    chk({nm, ".sync"}, 32'(sy), 32'd0);
    chk({nm, ".line_start"}, 32'(ls), 32'(e.ls));
    chk({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({nm, ".vblank"}, 32'(vb), 32'(e.vb));
    chk({nm, ".DrawX"}, x, 32'(e.x));
    chk({nm, ".DrawY"}, y, 32'(e.y));
  endtask

  task automatic check_all();
    exp_t ea, eb;
    ea = model(k, DA, PA, 1'b0, 1'b0);
    eb = model(k, DB, PB, 1'b1, 1'b1);
    check_dut("A", ea, ce_a, pclk_a, hs_a, vs_a, bl_a, sy_a, ls_a, fs_a, vb_a, 32'(x_a), 32'(y_a));
    check_dut("B", eb, ce_b, pclk_b, hs_b, vs_b, bl_b, sy_b, ls_b, fs_b, vb_b, 32'(x_b), 32'(y_b));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("A.frame_count", 32'(fc_a), 32'(ea.fc));
    chk("B.frame_count", 32'(fc_b), 32'(eb.fc));
`endif
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check_all();
    end
  endtask

  initial begin
    // Reset held, then released with En low: everything at reset values.
    step(4);
    Reset = 1'b0;
    step(5);

    // Run more than two frames of the slower instance.
    En = 1'b1;
    step(2 * FT * DB + 37);

    // Mid-frame halt for 10 Clk, then restart from (0,0).
    En = 1'b0;
    step(10);
    En = 1'b1;
    step(FT * DB + 5);

    // Random run lengths and halt lengths.
    for (int r = 0; r < 6; r++) begin
      step($urandom_range(600, 40));
      En = 1'b0;
      step($urandom_range(12, 1));
      En = 1'b1;
    end

    // Instance A reaches column 10 (first hsync column) after 11 ticks = 22 edges.
    En = 1'b0;
    step(2);
    En = 1'b1;
    step((HA + HF + 1) * DA);
    chk("A.hs_in_sync", 32'(hs_a), 32'd0);
    chk("A.x_in_sync", 32'(x_a), 32'(HA + HF));
    #1 Reset = 1'b1;
    #1;
    chk("A.hs_async_reset", 32'(hs_a), 32'd1);
    chk("A.x_async_reset", 32'(x_a), 32'd0);
    chk("B.hs_async_reset", 32'(hs_b), 32'd0);
    step(3);
    Reset = 1'b0;
    step(3 * FT * DA);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("A.frame_count_3", 32'(fc_a), 32'd3);
`endif
    step(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator, the next-generation VGA timing source for the display path.
- Derives a pixel clock-enable from the 50 MHz system clock and runs programmable horizontal and vertical counters.
- Produces registered sync, blank and frame/line markers for any porch/sync geometry, with selectable polarity.
- Provides a configurable sync/blank delay so colour pipelines (sprite, font, frame-buffer lookups) stay aligned with sync.

Parameters:
CW, 10, width of DrawX/DrawY and internal counters
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of hs (0 = active low)
VS_POL, 0, active level of vs (0 = active low)
CLK_DIV, 2, Clk cycles per pixel (>= 2)
PIPE, 0, extra pixel ticks of delay on hs/vs/blank/markers relative to DrawX/DrawY (0..7)

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-high reset
En  in  1  run enable; 0 = synchronous halt and rewind
pixel_ce  out  1  one-Clk pulse per pixel tick
pixel_clk  out  1  divided pixel clock for the DAC
hs  out  1  horizontal sync, polarity HS_POL
vs  out  1  vertical sync, polarity VS_POL
blank  out  1  1 = visible region, 0 = blanking
sync  out  1  composite sync, constant 0
DrawX  out  CW  current pixel column
DrawY  out  CW  current line
line_start  out  1  one-pixel-tick pulse at column 0 of every line
frame_start  out  1  one-pixel-tick pulse at column 0, line 0
vblank  out  1  1 while DrawY >= V_ACTIVE (after PIPE delay)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if H_TOTAL or V_TOTAL > 2^CW, or CLK_DIV < 2.
- Reset (async): div counter = 0, DrawX = DrawY = 0, hs = ~HS_POL, vs = ~VS_POL, blank = 0, pixel_ce = pixel_clk = line_start = frame_start = vblank = 0, delay pipe cleared to the same inactive values.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pixel_ce = 1 in the Clk cycle where div_cnt == CLK_DIV-1.
- pixel_clk is registered: 1 while div_cnt < CLK_DIV/2 (integer division), else 0. Square wave for even CLK_DIV.
- Counters update only on Clk edges where pixel_ce = 1:
  - DrawX increments; at H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps V_TOTAL-1 -> 0 on that same tick.
- Stage-0 decode, registered from the next counter value so it aligns with DrawX/DrawY:
  - hs active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (whole lines).
  - blank = (x < H_ACTIVE) && (y < V_ACTIVE).
  - line_start = (x == 0); frame_start = (x == 0 && y == 0); vblank = (y >= V_ACTIVE).
- Delay pipe: the stage-0 signals pass through a PIPE-deep shift register advanced on pixel_ce. PIPE = 0 means outputs are stage-0 directly.
  - line_start and frame_start are therefore high for exactly CLK_DIV Clk cycles each.
- En = 0, sampled each Clk:
  - Divider, counters and pipe are held at their reset values; outputs show their reset values.
  - On the first Clk with En = 1, counting resumes from (0,0) and the first pixel_ce arrives CLK_DIV cycles later.
  - Deassertion mid-frame aborts the frame; no partial-frame recovery.
- Simultaneous line and frame wrap on one tick: both wraps occur, and frame_start and line_start assert together.
- sync tied to 0.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- Defined: adds output frame_count [15:0].
  - Reset/En = 0 value is 0.
  - Increments by 1 on each pixel tick in which stage-0 frame_start is 1, wrapping 16'hFFFF -> 0.
  - Not delayed by PIPE.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Default params, Reset pulse then En = 1 -> pixel_ce period 2 Clk; DrawX runs 0..799; DrawY runs 0..524; frame = 420000 pixel ticks.
- Default params -> hs low exactly while DrawX in 656..751; vs low exactly while DrawY in 490..491; blank = 1 only for DrawX < 640 and DrawY < 480.
- HS_POL = 1, VS_POL = 1, CLK_DIV = 4 -> hs high for 96 ticks, pixel_clk high 2 / low 2 Clk cycles, pixel_ce every 4 Clk.
- PIPE = 3 -> blank falls 3 pixel ticks after DrawX goes 639 -> 640; frame_start rises 3 ticks after DrawX = DrawY = 0.
- En dropped at DrawX = 300, DrawY = 200 for 10 Clk, then raised -> all outputs at reset values while low; restart at (0,0) with frame_start asserted.
- Async Reset asserted mid-hsync -> hs returns to the inactive level immediately without waiting for Clk; with VGA_TIMING_FRAME_CNT_EN, frame_count = 0, then reads 3 after 3 complete frames.
